// File: rtl/cnn_accel_ctrl.sv
// Bus-mapped controller for the combinational CNN datapath: operand shadows,
// a start/settle/capture sequencer, and status/interrupt reporting.
module cnn_accel_ctrl #(
    parameter int COMPUTE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_valid,
    input  logic        bus_write,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic [63:0] acc_image,
    output logic [71:0] acc_kernel,
    input  logic [8:0]  acc_output_map,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, CAPTURE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(COMPUTE_CYCLES - 1);

    localparam logic [2:0] A_IMG_LO = 3'd0;
    localparam logic [2:0] A_IMG_HI = 3'd1;
    localparam logic [2:0] A_KER0   = 3'd2;
    localparam logic [2:0] A_KER1   = 3'd3;
    localparam logic [2:0] A_KER2   = 3'd4;
    localparam logic [2:0] A_CTRL   = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;
    localparam logic [2:0] A_RESULT = 3'd7;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] img_lo_q, img_lo_d;
    logic [31:0] img_hi_q, img_hi_d;
    logic [31:0] ker0_q, ker0_d;
    logic [31:0] ker1_q, ker1_d;
    logic [7:0]  ker2_q, ker2_d;
    logic        irq_en_q, irq_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [8:0]  result_q, result_d;
    logic [63:0] acc_image_q, acc_image_d;
    logic [71:0] acc_kernel_q, acc_kernel_d;
    logic        bus_ready_q, bus_ready_d;
    logic [31:0] bus_rdata_q, bus_rdata_d;

    logic accept;
    logic wr_en;
    logic rd_en;
    logic start_req;

    always_comb begin
        accept    = bus_valid && !bus_ready_q;
        wr_en     = accept && bus_write;
        rd_en     = accept && !bus_write;
        start_req = wr_en && (bus_addr == A_CTRL) && bus_wdata[0];

        state_d      = state_q;
        cnt_d        = cnt_q;
        img_lo_d     = img_lo_q;
        img_hi_d     = img_hi_q;
        ker0_d       = ker0_q;
        ker1_d       = ker1_q;
        ker2_d       = ker2_q;
        irq_en_d     = irq_en_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        result_d     = result_q;
        acc_image_d  = acc_image_q;
        acc_kernel_d = acc_kernel_q;
        bus_ready_d  = accept;
        bus_rdata_d  = '0;

        // Reads sample pre-edge state, so a STATUS read on the capture edge sees busy.
        if (rd_en) begin
            case (bus_addr)
                A_IMG_LO: bus_rdata_d = img_lo_q;
                A_IMG_HI: bus_rdata_d = img_hi_q;
                A_KER0:   bus_rdata_d = ker0_q;
                A_KER1:   bus_rdata_d = ker1_q;
                A_KER2:   bus_rdata_d = {24'd0, ker2_q};
                A_CTRL:   bus_rdata_d = {30'd0, irq_en_q, 1'b0};
                A_STATUS: bus_rdata_d = {29'd0, err_q, done_q, busy_q};
                A_RESULT: bus_rdata_d = {23'd0, result_q};
            endcase
        end

        if (wr_en) begin
            case (bus_addr)
                A_IMG_LO: img_lo_d = bus_wdata;
                A_IMG_HI: img_hi_d = bus_wdata;
                A_KER0:   ker0_d   = bus_wdata;
                A_KER1:   ker1_d   = bus_wdata;
                A_KER2:   ker2_d   = bus_wdata[7:0];
                A_CTRL:   irq_en_d = bus_wdata[1];
                A_STATUS: begin
                    if (bus_wdata[1]) done_d = 1'b0;
                    if (bus_wdata[2]) err_d  = 1'b0;
                end
                default: ;
            endcase
        end

        // Sequencer updates come after the W1C clears so that hardware sets win.
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            LOAD: begin
                acc_image_d  = {img_hi_q, img_lo_q};
                acc_kernel_d = {ker2_q, ker1_q, ker0_q};
                cnt_d        = CNT_INIT;
                state_d      = COMPUTE;
            end
            COMPUTE: begin
                if (cnt_q == 8'd0) state_d = CAPTURE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            CAPTURE: begin
                result_d = acc_output_map;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase

        if (start_req && (state_q != IDLE)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            img_lo_q     <= '0;
            img_hi_q     <= '0;
            ker0_q       <= '0;
            ker1_q       <= '0;
            ker2_q       <= '0;
            irq_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            result_q     <= '0;
            acc_image_q  <= '0;
            acc_kernel_q <= '0;
            bus_ready_q  <= 1'b0;
            bus_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            img_lo_q     <= img_lo_d;
            img_hi_q     <= img_hi_d;
            ker0_q       <= ker0_d;
            ker1_q       <= ker1_d;
            ker2_q       <= ker2_d;
            irq_en_q     <= irq_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            result_q     <= result_d;
            acc_image_q  <= acc_image_d;
            acc_kernel_q <= acc_kernel_d;
            bus_ready_q  <= bus_ready_d;
            bus_rdata_q  <= bus_rdata_d;
        end
    end

    assign bus_ready  = bus_ready_q;
    assign bus_rdata  = bus_rdata_q;
    assign acc_image  = acc_image_q;
    assign acc_kernel = acc_kernel_q;
    assign irq        = done_q & irq_en_q;

endmodule

// File: tb/tb_cnn_accel_ctrl.sv
// Scoreboard bench for cnn_accel_ctrl: a main instance with the default settle
// window plus two instances (1 and 7 cycles) sharing the same bus stimulus.
module tb_cnn_accel_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busValid = 1'b0;
    logic        busWrite = 1'b0;
    logic [2:0]  busAddr = '0;
    logic [31:0] busWdata = '0;
    logic [8:0]  mapMain = '0;
    logic [8:0]  mapC1 = '0;
    logic [8:0]  mapC7 = '0;

    logic [31:0] rdataMain, rdataC1, rdataC7;
    logic        readyMain, readyC1, readyC7;
    logic [63:0] imageMain, imageC1, imageC7;
    logic [71:0] kernelMain, kernelC1, kernelC7;
    logic        irqMain, irqC1, irqC7;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    logic [31:0] expQ[$];
    bit          chkQ[$];
    string       tagQ[$];

    int   riseMain = -1, riseC1 = -1, riseC7 = -1;
    logic irqPrevMain = 1'b0, irqPrevC1 = 1'b0, irqPrevC7 = 1'b0;

    logic [2:0]  burstAddr [6];
    logic [31:0] burstExp  [6];

    cnn_accel_ctrl #(.COMPUTE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .bus_valid(busValid), .bus_write(busWrite), .bus_addr(busAddr), .bus_wdata(busWdata),
        .bus_rdata(rdataMain), .bus_ready(readyMain),
        .acc_image(imageMain), .acc_kernel(kernelMain), .acc_output_map(mapMain),
        .irq(irqMain)
    );

    cnn_accel_ctrl #(.COMPUTE_CYCLES(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n),
        .bus_valid(busValid), .bus_write(busWrite), .bus_addr(busAddr), .bus_wdata(busWdata),
        .bus_rdata(rdataC1), .bus_ready(readyC1),
        .acc_image(imageC1), .acc_kernel(kernelC1), .acc_output_map(mapC1),
        .irq(irqC1)
    );

    cnn_accel_ctrl #(.COMPUTE_CYCLES(7)) u_dut_c7 (
        .clk(clk), .rst_n(rst_n),
        .bus_valid(busValid), .bus_write(busWrite), .bus_addr(busAddr), .bus_wdata(busWdata),
        .bus_rdata(rdataC7), .bus_ready(readyC7),
        .acc_image(imageC7), .acc_kernel(kernelC7), .acc_output_map(mapC7),
        .irq(irqC7)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge N (and before edge N+1) cyc reads N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard consumer: every completion pops one expectation, reads are compared.
    always @(negedge clk) begin
        if (readyMain) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected bus_ready", 72'd1, 72'd0);
            end else begin
                logic [31:0] e;
                bit          c;
                string       t;
                e = expQ.pop_front();
                c = chkQ.pop_front();
                t = tagQ.pop_front();
                if (c) checkOutput(t, rdataMain, e);
            end
        end
    end

    // Records the edge on which each instance's interrupt most recently rose.
    always @(negedge clk) begin
        irqPrevMain <= irqMain;
        irqPrevC1   <= irqC1;
        irqPrevC7   <= irqC7;
        if (irqMain && !irqPrevMain) riseMain <= cyc;
        if (irqC1 && !irqPrevC1)     riseC1   <= cyc;
        if (irqC7 && !irqPrevC7)     riseC7   <= cyc;
    end

    // One bus transfer; called just after a rising edge, returns 1ns after the completion edge.
    task automatic applyStimulus(input logic write, input logic [2:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRd, input string tag);
        bit got;
        expQ.push_back(expRd);
        chkQ.push_back(!write);
        tagQ.push_back(tag);
        busValid = 1'b1;
        busWrite = write;
        busAddr  = addr;
        busWdata = wdata;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (readyMain) got = 1'b1;
        end
        busValid = 1'b0;
        if (!got) checkOutput({tag, " timeout"}, 72'd0, 72'd1);
    endtask

    task automatic writeReg(input logic [2:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 32'd0, "write");
    endtask

    task automatic readReg(input logic [2:0] addr, input logic [31:0] expected, input string tag);
        applyStimulus(1'b0, addr, 32'd0, expected, tag);
    endtask

    // Start with irq_en set; returns the index of the accepting edge.
    task automatic startJob(output int e);
        writeReg(3'd5, 32'h3);
        e = cyc;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        int prevReady;
        int k;

        burstAddr[0] = 3'd0; burstExp[0] = 32'hDEADBEEF;
        burstAddr[1] = 3'd1; burstExp[1] = 32'h01234567;
        burstAddr[2] = 3'd2; burstExp[2] = 32'h11111111;
        burstAddr[3] = 3'd3; burstExp[3] = 32'h22222222;
        burstAddr[4] = 3'd4; burstExp[4] = 32'h000000A5;
        burstAddr[5] = 3'd7; burstExp[5] = 32'h000001A5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset bus_ready", readyMain, 0);
        checkOutput("reset bus_rdata", rdataMain, 0);
        checkOutput("reset acc_image", imageMain, 0);
        checkOutput("reset acc_kernel", kernelMain, 0);
        checkOutput("reset irq", irqMain, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        readReg(3'd6, 32'h0, "status after reset");

        // Operand setup
        writeReg(3'd0, 32'hDEADBEEF);
        writeReg(3'd1, 32'h01234567);
        writeReg(3'd2, 32'h11111111);
        writeReg(3'd3, 32'h22222222);
        writeReg(3'd4, 32'hFFFFFFA5);
        readReg(3'd0, 32'hDEADBEEF, "img_lo readback");
        readReg(3'd4, 32'h000000A5, "ker2 upper bits zero");
        readReg(3'd5, 32'h0, "ctrl before start");

        // Basic job; the side instances see their map change mid-window
        mapMain = 9'h1A5;
        mapC1   = 9'h033;
        mapC7   = 9'h0AA;
        startJob(e);
        fork
            begin
                wait (cyc == e + 2);
                @(negedge clk);
                mapC1 = 9'h0CC;
                wait (cyc == e + 6);
                @(negedge clk);
                mapC7 = 9'h155;
            end
        join_none
        @(negedge clk);
        checkOutput("acc_image before load edge", imageMain, 0);
        @(posedge clk);
        #1;
        checkOutput("acc_image after load", imageMain, 64'h01234567DEADBEEF);
        checkOutput("acc_kernel after load", kernelMain, 72'hA5_22222222_11111111);
        readReg(3'd6, 32'h1, "busy during compute");
        readReg(3'd6, 32'h1, "status on capture edge");
        readReg(3'd6, 32'h2, "done after capture");
        readReg(3'd7, 32'h1A5, "result");
        repeat (4) @(posedge clk);
        #1;
        checkOutput("done latency C=2", riseMain - e, 4);
        checkOutput("done latency C=1", riseC1 - e, 3);
        checkOutput("done latency C=7", riseC7 - e, 9);
        readReg(3'd5, 32'h2, "ctrl irq_en readback");
        readReg(3'd7, 32'h1A5, "result again");
        checkOutput("result C=1", rdataC1, 32'h0CC);
        checkOutput("result C=7", rdataC7, 32'h155);

        // Back-to-back reads with bus_valid held high
        busValid = 1'b1;
        busWrite = 1'b0;
        busAddr  = burstAddr[0];
        expQ.push_back(burstExp[0]);
        chkQ.push_back(1'b1);
        tagQ.push_back("burst read");
        prevReady = -1;
        k = 0;
        for (int i = 0; i < 40 && k < 6; i++) begin
            @(posedge clk);
            #1;
            if (readyMain) begin
                if (prevReady >= 0) checkOutput("burst ready spacing", cyc - prevReady, 2);
                prevReady = cyc;
                k++;
                if (k < 6) begin
                    busAddr = burstAddr[k];
                    expQ.push_back(burstExp[k]);
                    chkQ.push_back(1'b1);
                    tagQ.push_back("burst read");
                end
            end
        end
        busValid = 1'b0;
        checkOutput("burst completions", k, 6);

        // Start and shadow write while busy
        startJob(e);
        writeReg(3'd5, 32'h3);
        writeReg(3'd0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("latency with collision", riseMain - e, 4);
        checkOutput("acc_image held", imageMain, 64'h01234567DEADBEEF);
        readReg(3'd0, 32'h0, "img_lo shadow while busy");
        readReg(3'd6, 32'h6, "done and err");
        writeReg(3'd6, 32'h4);
        readReg(3'd6, 32'h2, "err cleared");

        // W1C of done on the capture edge
        startJob(e);
        readReg(3'd6, 32'h1, "busy before race");
        writeReg(3'd6, 32'h2);
        readReg(3'd6, 32'h2, "done kept on race");
        checkOutput("irq high after race", irqMain, 1);
        writeReg(3'd6, 32'h2);
        checkOutput("irq dropped after clear", irqMain, 0);
        readReg(3'd6, 32'h0, "done cleared");
        repeat (8) @(posedge clk);
        #1;

        // Reset in the middle of a job
        startJob(e);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-job reset acc_image", imageMain, 0);
        checkOutput("mid-job reset acc_kernel", kernelMain, 0);
        checkOutput("mid-job reset irq", irqMain, 0);
        checkOutput("mid-job reset bus_ready", readyMain, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("irq stays low after reset", irqMain, 0);
        readReg(3'd6, 32'h0, "status after mid-job reset");
        readReg(3'd7, 32'h0, "no capture after reset");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
